// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target (and, later, the I2C master):
//   - i2c_state_t : protocol state encoding of the target FSM
//   - DIR_WRITE / DIR_READ : values of the R/W bit in the address byte
//   - ACK_LEVEL / NACK_LEVEL : SDA level during the acknowledge bit
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        WR_DATA  = 4'd3,
        WR_ACK   = 4'd4,
        RD_LOAD  = 4'd5,
        RD_DATA  = 4'd6,
        RD_ACK   = 4'd7,
        IGNORE   = 4'd8
    } i2c_state_t;

    localparam logic DIR_WRITE  = 1'b0;
    localparam logic DIR_READ   = 1'b1;

    localparam logic ACK_LEVEL  = 1'b0;
    localparam logic NACK_LEVEL = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// -----------------------------------------------------------------------------
// i2c_line_sync
// Brings the raw SCL/SDA pad inputs into the clk domain and derives the bus
// events the protocol logic needs. Shared between target and master.
//
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   scl_in     : raw SCL pad input
//   sda_in     : raw SDA pad input
//   sda        : synchronized SDA level
//   scl_rise   : one-cycle strobe, synchronized SCL went 0 -> 1
//   scl_fall   : one-cycle strobe, synchronized SCL went 1 -> 0
//   start_det  : one-cycle strobe, SDA fell while SCL stayed high
//   stop_det   : one-cycle strobe, SDA rose while SCL stayed high
//
// Synchronizers reset to 1 (idle bus level) so that leaving reset never
// produces a spurious edge, START or STOP.
// -----------------------------------------------------------------------------
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    localparam int LINE_SCL = 0;
    localparam int LINE_SDA = 1;

    logic [1:0] raw_lines;
    logic [1:0] cur_lines;
    logic [1:0] prev_lines;

    assign raw_lines = {sda_in, scl_in};

    // One identical lane per bus line: SYNC_STAGES-deep chain followed by a
    // history flop used for edge detection.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] chain_reg;
            logic                   prev_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    chain_reg <= '1;
                    prev_reg  <= 1'b1;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw_lines[gi]};
                    prev_reg  <= chain_reg[SYNC_STAGES-1];
                end
            end

            assign cur_lines[gi]  = chain_reg[SYNC_STAGES-1];
            assign prev_lines[gi] = prev_reg;
        end
    endgenerate

    logic scl_stable_high;

    // START/STOP only count when SCL was high both before and after the
    // SDA transition, so an SDA change racing an SCL edge is not misread.
    assign scl_stable_high = cur_lines[LINE_SCL] & prev_lines[LINE_SCL];

    assign sda       = cur_lines[LINE_SDA];
    assign scl_rise  =  cur_lines[LINE_SCL] & ~prev_lines[LINE_SCL];
    assign scl_fall  = ~cur_lines[LINE_SCL] &  prev_lines[LINE_SCL];
    assign start_det = scl_stable_high &  prev_lines[LINE_SDA] & ~cur_lines[LINE_SDA];
    assign stop_det  = scl_stable_high & ~prev_lines[LINE_SDA] &  cur_lines[LINE_SDA];

endmodule

// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target
// Single-address 7-bit I2C target. Detects START / repeated START / STOP,
// ACKs its own address, hands written bytes to local logic and fetches read
// bytes from local logic, stretching SCL while waiting for them.
//
// Ports:
//   clk, rst         : system clock, synchronous active-high reset
//   i2c_scl_in       : raw SCL pad input
//   i2c_sda_in       : raw SDA pad input
//   i2c_scl_drive_n  : 0 = pull SCL low (stretch), 1 = release
//   i2c_sda_drive_n  : 0 = pull SDA low, 1 = release
//   addressed        : own address ACKed, until STOP / Sr / NACKed read
//   rw               : R/W bit of the current addressed transaction
//   start_det        : one-cycle pulse on START or repeated START
//   stop_det         : one-cycle pulse on STOP
//   rx_data          : last byte written by the master
//   rx_valid         : one-cycle pulse, rx_data updated
//   tx_request       : level, a read byte is needed (SCL is being stretched)
//   tx_data          : read byte from local logic
//   tx_valid         : tx_data valid; consumed when tx_valid & tx_request
//
// All SDA changes happen in the cycle an SCL fall is detected, so the target
// never moves SDA while SCL is high (apart from releasing on START/STOP).
// -----------------------------------------------------------------------------
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl_in,
    input  logic       i2c_sda_in,
    output logic       i2c_scl_drive_n,
    output logic       i2c_sda_drive_n,
    output logic       addressed,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_request,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    // ------------------------------------------------------------------
    // Line conditioning
    // ------------------------------------------------------------------
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic bus_start;
    logic bus_stop;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (i2c_scl_in),
        .sda_in    (i2c_sda_in),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (bus_start),
        .stop_det  (bus_stop)
    );

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    i2c_state_t state_reg;
    logic [2:0] bit_cnt_reg;
    // Set once the bit phase that must precede the next acted-upon SCL fall
    // has happened (8th data rise in ADDR/WR_DATA, ACK rise in RD_ACK).
    // Keeps stray falls, such as the one right after START, from counting.
    logic       phase_done_reg;
    logic [7:0] shift_reg;
    logic [7:0] tx_shift_reg;
    logic       scl_drive_n_reg;
    logic       sda_drive_n_reg;
    logic       addressed_reg;
    logic       rw_reg;
    logic       start_det_reg;
    logic       stop_det_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       tx_request_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= 3'd0;
            phase_done_reg  <= 1'b0;
            shift_reg       <= 8'h00;
            tx_shift_reg    <= 8'h00;
            scl_drive_n_reg <= 1'b1;
            sda_drive_n_reg <= 1'b1;
            addressed_reg   <= 1'b0;
            rw_reg          <= 1'b0;
            start_det_reg   <= 1'b0;
            stop_det_reg    <= 1'b0;
            rx_data_reg     <= 8'h00;
            rx_valid_reg    <= 1'b0;
            tx_request_reg  <= 1'b0;
        end else begin
            start_det_reg <= 1'b0;
            stop_det_reg  <= 1'b0;
            rx_valid_reg  <= 1'b0;

            if (bus_stop) begin
                // STOP wins over any bit event in the same cycle.
                stop_det_reg    <= 1'b1;
                scl_drive_n_reg <= 1'b1;
                sda_drive_n_reg <= 1'b1;
                addressed_reg   <= 1'b0;
                tx_request_reg  <= 1'b0;
                phase_done_reg  <= 1'b0;
                state_reg       <= IDLE;
            end else if (bus_start) begin
                // START and repeated START share one path.
                start_det_reg   <= 1'b1;
                scl_drive_n_reg <= 1'b1;
                sda_drive_n_reg <= 1'b1;
                addressed_reg   <= 1'b0;
                tx_request_reg  <= 1'b0;
                bit_cnt_reg     <= 3'd0;
                phase_done_reg  <= 1'b0;
                state_reg       <= ADDR;
            end else begin
                case (state_reg)
                    IDLE: begin
                        // Only START leaves IDLE; handled above.
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], sda_s};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                phase_done_reg <= 1'b1;
                            end
                        end else if (scl_fall && phase_done_reg) begin
                            phase_done_reg <= 1'b0;
                            // General call (0x00) and 10-bit prefixes never
                            // equal a normal 7-bit ADDRESS, so they land in
                            // IGNORE here as plain mismatches.
                            if (shift_reg[7:1] == ADDRESS) begin
                                sda_drive_n_reg <= ACK_LEVEL;
                                rw_reg          <= shift_reg[0];
                                addressed_reg   <= 1'b1;
                                state_reg       <= ADDR_ACK;
                            end else begin
                                state_reg <= IGNORE;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_drive_n_reg <= 1'b1;
                            if (rw_reg == DIR_READ) begin
                                // Start stretching immediately: SCL is low now.
                                scl_drive_n_reg <= 1'b0;
                                tx_request_reg  <= 1'b1;
                                state_reg       <= RD_LOAD;
                            end else begin
                                state_reg <= WR_DATA;
                            end
                        end
                    end

                    WR_DATA: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], sda_s};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                rx_data_reg    <= {shift_reg[6:0], sda_s};
                                rx_valid_reg   <= 1'b1;
                                phase_done_reg <= 1'b1;
                            end
                        end else if (scl_fall && phase_done_reg) begin
                            phase_done_reg  <= 1'b0;
                            sda_drive_n_reg <= ACK_LEVEL;
                            state_reg       <= WR_ACK;
                        end
                    end

                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_drive_n_reg <= 1'b1;
                            state_reg       <= WR_DATA;
                        end
                    end

                    RD_LOAD: begin
                        if (tx_valid && tx_request_reg) begin
                            // MSB goes out now; the remaining seven bits are
                            // kept left-aligned for the following falls.
                            sda_drive_n_reg <= tx_data[7];
                            tx_shift_reg    <= {tx_data[6:0], 1'b0};
                            tx_request_reg  <= 1'b0;
                            scl_drive_n_reg <= 1'b1;
                            bit_cnt_reg     <= 3'd0;
                            state_reg       <= RD_DATA;
                        end
                    end

                    RD_DATA: begin
                        // Here the counter counts falls: falls 1..7 present
                        // bits 6..0, fall 8 hands SDA to the master for ACK.
                        if (scl_fall) begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                sda_drive_n_reg <= 1'b1;
                                phase_done_reg  <= 1'b0;
                                state_reg       <= RD_ACK;
                            end else begin
                                sda_drive_n_reg <= tx_shift_reg[7];
                                tx_shift_reg    <= {tx_shift_reg[6:0], 1'b0};
                            end
                        end
                    end

                    RD_ACK: begin
                        if (scl_rise && !phase_done_reg) begin
                            if (sda_s == ACK_LEVEL) begin
                                phase_done_reg <= 1'b1;
                            end else begin
                                addressed_reg <= 1'b0;
                                state_reg     <= IGNORE;
                            end
                        end else if (scl_fall && phase_done_reg) begin
                            phase_done_reg  <= 1'b0;
                            scl_drive_n_reg <= 1'b0;
                            tx_request_reg  <= 1'b1;
                            state_reg       <= RD_LOAD;
                        end
                    end

                    IGNORE: begin
                        // Lines stay released until START or STOP.
                    end

                    default: begin
                        scl_drive_n_reg <= 1'b1;
                        sda_drive_n_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end
                endcase
            end
        end
    end

    assign i2c_scl_drive_n = scl_drive_n_reg;
    assign i2c_sda_drive_n = sda_drive_n_reg;
    assign addressed       = addressed_reg;
    assign rw              = rw_reg;
    assign start_det       = start_det_reg;
    assign stop_det        = stop_det_reg;
    assign rx_data         = rx_data_reg;
    assign rx_valid        = rx_valid_reg;
    assign tx_request      = tx_request_reg;

endmodule
